// File: rtl/adv7513_init_sequencer.sv
// -----------------------------------------------------------------------------
// adv7513_init_sequencer
//
// Walks a fixed 12-entry {register, data} table and hands each entry to an
// external I2C write master.
// - A NACKed write is retried up to RETRY_MAX times.
// - Once retries are exhausted, the block parks in ERROR.
// - After the last entry it parks in DONE.
//
// Optional feature (compile-time macro ADV_HPD_REINIT_EN):
//   A rising edge on HPD acts as a start request in IDLE/DONE/ERROR.
//   An edge seen while a run is in progress is remembered, and the table is
//   re-run once after the current run finishes. Without the macro, HPD is
//   ignored.
//
// Ports:
//   Clock        system clock, rising-edge active
//   Reset        asynchronous active-high reset
//   Start        level request to run the sequence (sampled in IDLE)
//   HPD          hot-plug detect, already synchronous to Clock
//   I2C_Req      write request to the I2C master (high in ISSUE/WAIT)
//   I2C_DevAddr  device write address of the current transfer
//   I2C_RegAddr  register address of the current transfer
//   I2C_Data     data byte of the current transfer
//   I2C_Ack      one-cycle completion pulse from the master
//   I2C_Nack     NACK flag, valid with I2C_Ack
//   Busy         sequence in progress (ISSUE/WAIT/GAP)
//   Done         table written successfully (level)
//   Error        retries exhausted on an entry (level)
//   Index        table entry currently being written
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module adv7513_init_sequencer #(
    parameter logic [7:0] DEV_ADDR  = 8'h72,
    parameter int         RETRY_MAX = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       HPD,
    output logic       I2C_Req,
    output logic [7:0] I2C_DevAddr,
    output logic [7:0] I2C_RegAddr,
    output logic [7:0] I2C_Data,
    input  logic       I2C_Ack,
    input  logic       I2C_Nack,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    output logic [3:0] Index
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [2:0] RETRY_LIMIT = 3'(RETRY_MAX);
    localparam logic [3:0] LAST_INDEX  = 4'd11;

    // Initialisation table: {register address, data}.
    function automatic logic [15:0] rom_entry(input logic [3:0] idx);
        logic [15:0] val;
        case (idx)
            4'd0:    val = 16'h4110;
            4'd1:    val = 16'h9803;
            4'd2:    val = 16'h9AE0;
            4'd3:    val = 16'h9C30;
            4'd4:    val = 16'h9D61;
            4'd5:    val = 16'hA2A4;
            4'd6:    val = 16'hA3A4;
            4'd7:    val = 16'hE0D0;
            4'd8:    val = 16'hF900;
            4'd9:    val = 16'h1500;
            4'd10:   val = 16'h1630;
            4'd11:   val = 16'hAF04;
            default: val = 16'h0000;
        endcase
        return val;
    endfunction

    state_t      state_r, state_next_s;
    logic [3:0]  index_r, index_next_s;
    logic [2:0]  retry_r, retry_next_s;
    logic        pending_r, pending_next_s;
    logic        hpd_rise_s;
    logic        txn_next_s;

    logic        req_r, busy_r, done_r, error_r;
    logic [7:0]  dev_addr_r, reg_addr_r, data_r;

`ifdef ADV_HPD_REINIT_EN
    logic        hpd_prev_r;

    assign hpd_rise_s = HPD & ~hpd_prev_r;

    // Previous HPD sample for rising-edge detection.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hpd_prev_r <= 1'b0;
        end else begin
            hpd_prev_r <= HPD;
        end
    end
`else
    logic        hpd_unused_s;

    assign hpd_unused_s = HPD;
    assign hpd_rise_s   = 1'b0;
`endif

    // Next-state, table index, retry count and deferred re-run request.
    always_comb begin
        state_next_s   = state_r;
        index_next_s   = index_r;
        retry_next_s   = retry_r;
        pending_next_s = pending_r;
        case (state_r)
            ST_IDLE: begin
                if (Start || hpd_rise_s) begin
                    state_next_s = ST_ISSUE;
                    index_next_s = 4'd0;
                    retry_next_s = 3'd0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (I2C_Ack) begin
                    if (!I2C_Nack) begin
                        retry_next_s = 3'd0;
                        if (index_r == LAST_INDEX) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_GAP;
                            index_next_s = index_r + 4'd1;
                        end
                    end else if (retry_r < RETRY_LIMIT) begin
                        state_next_s = ST_GAP;
                        retry_next_s = retry_r + 3'd1;
                    end else begin
                        state_next_s = ST_ERROR;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_GAP: begin
                state_next_s = ST_ISSUE;
            end
            ST_DONE, ST_ERROR: begin
                // A fresh HPD edge or one remembered from the last run restarts;
                // a plain Start level never auto-restarts from here.
                if (hpd_rise_s || pending_r) begin
                    state_next_s   = ST_ISSUE;
                    index_next_s   = 4'd0;
                    retry_next_s   = 3'd0;
                    pending_next_s = 1'b0;
                end else if (!Start) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // An HPD edge mid-run is remembered and served once the run ends.
        if ((state_r == ST_ISSUE || state_r == ST_WAIT || state_r == ST_GAP) && hpd_rise_s) begin
            pending_next_s = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end
    end

    assign txn_next_s = (state_next_s == ST_ISSUE) || (state_next_s == ST_WAIT);

    // State registers plus outputs registered from the next state so they
    // line up with state_r and are cleared asynchronously by Reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            index_r    <= 4'd0;
            retry_r    <= 3'd0;
            pending_r  <= 1'b0;
            req_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            dev_addr_r <= 8'h00;
            reg_addr_r <= 8'h00;
            data_r     <= 8'h00;
        end else begin
            state_r    <= state_next_s;
            index_r    <= index_next_s;
            retry_r    <= retry_next_s;
            pending_r  <= pending_next_s;
            req_r      <= txn_next_s;
            busy_r     <= txn_next_s || (state_next_s == ST_GAP);
            done_r     <= (state_next_s == ST_DONE);
            error_r    <= (state_next_s == ST_ERROR);
            dev_addr_r <= txn_next_s ? DEV_ADDR : 8'h00;
            {reg_addr_r, data_r} <= txn_next_s ? rom_entry(index_next_s) : 16'h0000;
        end
    end

    assign I2C_Req     = req_r;
    assign I2C_DevAddr = dev_addr_r;
    assign I2C_RegAddr = reg_addr_r;
    assign I2C_Data    = data_r;
    assign Busy        = busy_r;
    assign Done        = done_r;
    assign Error       = error_r;
    assign Index       = index_r;

endmodule

// File: tb/tb_adv7513_init_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for adv7513_init_sequencer.
//
// Structure:
// - An I2C master responder acks each request after a chosen latency.
//   It NACKs according to a per-entry plan.
// - A monitor records every request (register, data).
// - A table-level reference model expands the NACK plan into the expected
//   list of writes and the expected final outcome.
//
// The HPD re-init scenarios are compiled when ADV_HPD_REINIT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adv7513_init_sequencer;

    localparam int RMAX = 3;

    logic       Clock = 1'b0;
    logic       Reset, Start, HPD;
    logic       I2C_Req, I2C_Ack, I2C_Nack;
    logic [7:0] I2C_DevAddr, I2C_RegAddr, I2C_Data;
    logic       Busy, Done, Error;
    logic [3:0] Index;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rom_tab [12] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30,
                                  16'h9D61, 16'hA2A4, 16'hA3A4, 16'hE0D0,
                                  16'hF900, 16'h1500, 16'h1630, 16'hAF04};
    int          plan [12];
    int          nack_left [12];
    int          ack_lat = 5;
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];
    int          stable_err = 0;
    logic        req_prev = 1'b0;
    logic [15:0] cur_txn = 16'h0000;

    always #5 Clock = ~Clock;

    adv7513_init_sequencer #(.DEV_ADDR(8'h72), .RETRY_MAX(RMAX)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .HPD(HPD),
        .I2C_Req(I2C_Req), .I2C_DevAddr(I2C_DevAddr), .I2C_RegAddr(I2C_RegAddr),
        .I2C_Data(I2C_Data), .I2C_Ack(I2C_Ack), .I2C_Nack(I2C_Nack),
        .Busy(Busy), .Done(Done), .Error(Error), .Index(Index)
    );

    function automatic int entry_of(input logic [7:0] ra);
        for (int k = 0; k < 12; k++) begin
            if (rom_tab[k][15:8] == ra) return k;
        end
        return -1;
    endfunction

    // Monitor: log each request and flag address/data changes while Req is high.
    always @(negedge Clock) begin
        if (I2C_Req === 1'b1 && req_prev !== 1'b1) begin
            cur_txn = {I2C_RegAddr, I2C_Data};
            got_q.push_back(cur_txn);
            if (I2C_DevAddr !== 8'h72) stable_err++;
        end else if (I2C_Req === 1'b1 && {I2C_RegAddr, I2C_Data} !== cur_txn) begin
            stable_err++;
        end
        req_prev = I2C_Req;
    end

    // Responder: acks a request ack_lat cycles after Req rises, NACKing per plan.
    initial begin : responder
        int wcnt;
        int k;
        wcnt = 0;
        I2C_Ack = 1'b0;
        I2C_Nack = 1'b0;
        forever begin
            @(negedge Clock);
            I2C_Ack = 1'b0;
            I2C_Nack = 1'b0;
            if (I2C_Req === 1'b1 && Reset === 1'b0) begin
                if (wcnt >= ack_lat) begin
                    wcnt = 0;
                    I2C_Ack = 1'b1;
                    k = entry_of(I2C_RegAddr);
                    if (k >= 0 && nack_left[k] > 0) begin
                        I2C_Nack = 1'b1;
                        nack_left[k]--;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: expand the NACK plan into the expected write list.
    // Each entry is tried min(nacks, RMAX) + 1 times; more than RMAX NACKs
    // on one entry ends the run in ERROR at that entry.
    task automatic build_expect(output bit exp_done, output logic [3:0] exp_idx);
        int tries;
        exp_q.delete();
        exp_done = 1'b1;
        exp_idx  = 4'd11;
        for (int k = 0; k < 12; k++) begin
            tries = (plan[k] > RMAX) ? RMAX + 1 : plan[k] + 1;
            for (int t = 0; t < tries; t++) exp_q.push_back(rom_tab[k]);
            if (plan[k] > RMAX) begin
                exp_done = 1'b0;
                exp_idx  = 4'(k);
                break;
            end
        end
    endtask

    task automatic clear_plan();
        for (int k = 0; k < 12; k++) plan[k] = 0;
    endtask

    // Start a run, wait (bounded) for Done/Error and compare against the model.
    task automatic run_and_check(input string tag, input int lat, input bit hold);
        bit         ed;
        logic [3:0] ei;
        int         cyc;
        ack_lat   = lat;
        nack_left = plan;
        got_q.delete();
        build_expect(ed, ei);
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        if (!hold) Start = 1'b0;
        chk($sformatf("%s_first_req", tag), I2C_Req, 1'b1);
        chk($sformatf("%s_first_busy", tag), Busy, 1'b1);
        chk($sformatf("%s_first_index", tag), Index, 4'd0);
        chk($sformatf("%s_first_reg", tag), {I2C_RegAddr, I2C_Data}, 16'h4110);
        cyc = 0;
        while (!(Done === 1'b1 || Error === 1'b1) && cyc < 5000) begin
            @(negedge Clock);
            cyc++;
        end
        chk($sformatf("%s_timeout", tag), (cyc < 5000), 1'b1);
        chk($sformatf("%s_done", tag), Done, ed);
        chk($sformatf("%s_error", tag), Error, !ed);
        chk($sformatf("%s_index", tag), Index, ei);
        chk($sformatf("%s_busy_end", tag), Busy, 1'b0);
        chk($sformatf("%s_req_end", tag), I2C_Req, 1'b0);
        chk($sformatf("%s_count", tag), 16'(got_q.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_txn%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin : main
        int cyc;
        int cnt;
        Reset = 1'b1;
        Start = 1'b0;
        HPD   = 1'b0;
        clear_plan();
        nack_left = plan;
        repeat (3) @(negedge Clock);
        chk("reset_req", I2C_Req, 1'b0);
        chk("reset_busy", Busy, 1'b0);
        chk("reset_done", Done, 1'b0);
        chk("reset_error", Error, 1'b0);
        chk("reset_index", Index, 4'd0);
        chk("reset_addr", {I2C_DevAddr, I2C_RegAddr, I2C_Data} == 24'h0, 1'b1);
        Reset = 1'b0;

        // Clean run with a 5-cycle ack latency.
        clear_plan();
        run_and_check("clean", 5, 1'b0);
        @(negedge Clock);
        chk("clean_back_idle_done", Done, 1'b0);
        chk("clean_back_idle_busy", Busy, 1'b0);

        // One NACK on entry 3: 9C/30 appears twice.
        clear_plan();
        plan[3] = 1;
        run_and_check("nack1", int'($urandom_range(1, 6)), 1'b0);
        cnt = 0;
        foreach (got_q[i]) if (got_q[i] == 16'h9C30) cnt++;
        chk("nack1_9c_count", 16'(cnt), 16'd2);

        // Entry 5 always NACKs: four attempts, then ERROR at index 5.
        clear_plan();
        plan[5] = 1000;
        run_and_check("nackp", int'($urandom_range(1, 6)), 1'b0);
        @(negedge Clock);
        chk("nackp_back_idle", Error, 1'b0);

        // Reset pulsed in WAIT of entry 7 aborts the run.
        clear_plan();
        nack_left = plan;
        ack_lat   = 5;
        got_q.delete();
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        cyc = 0;
        while (!(Index === 4'd7 && I2C_Req === 1'b1) && cyc < 2000) begin
            @(negedge Clock);
            cyc++;
        end
        chk("rst_reach_entry7", (cyc < 2000), 1'b1);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        chk("rst_mid_req", I2C_Req, 1'b0);
        chk("rst_mid_busy", Busy, 1'b0);
        chk("rst_mid_index", Index, 4'd0);
        chk("rst_mid_flags", {Done, Error}, 2'b00);
        chk("rst_mid_addr", {I2C_DevAddr, I2C_RegAddr, I2C_Data} == 24'h0, 1'b1);
        @(negedge Clock);
        Reset = 1'b0;
        run_and_check("rst_rerun", 5, 1'b0);

        // Start held high: completes once and stays in DONE.
        clear_plan();
        run_and_check("hold", 3, 1'b1);
        repeat (20) @(negedge Clock);
        chk("hold_still_done", Done, 1'b1);
        chk("hold_no_rerun_busy", Busy, 1'b0);
        chk("hold_no_rerun_count", 16'(got_q.size()), 16'd12);
        Start = 1'b0;
        @(negedge Clock);
        chk("hold_release_done", Done, 1'b0);
        chk("hold_release_busy", Busy, 1'b0);

        // Random NACK plans and ack latencies.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 12; k++) begin
                plan[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, RMAX + 1)) : 0;
            end
            run_and_check($sformatf("rand%0d", r), int'($urandom_range(1, 6)), 1'b0);
            @(negedge Clock);
            chk($sformatf("rand%0d_idle", r), {Busy, Done, Error}, 3'b000);
        end

`ifdef ADV_HPD_REINIT_EN
        // HPD edge while parked in DONE starts a new run.
        clear_plan();
        run_and_check("hpd_base", 2, 1'b1);
        got_q.delete();
        nack_left = plan;
        HPD = 1'b1;
        @(negedge Clock);
        chk("hpd_done_restart_busy", Busy, 1'b1);
        chk("hpd_done_restart_index", Index, 4'd0);
        chk("hpd_done_restart_reg", {I2C_RegAddr, I2C_Data}, 16'h4110);
        cyc = 0;
        while (Done !== 1'b1 && cyc < 5000) begin
            @(negedge Clock);
            cyc++;
        end
        chk("hpd_done_rerun_end", Done, 1'b1);
        chk("hpd_done_rerun_count", 16'(got_q.size()), 16'd12);
        Start = 1'b0;
        HPD   = 1'b0;
        repeat (2) @(negedge Clock);
        chk("hpd_done_idle", {Busy, Done}, 2'b00);

        // HPD edge during entry 4: exactly one extra run.
        got_q.delete();
        nack_left = plan;
        ack_lat   = 2;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        cyc = 0;
        while (!(Index === 4'd4 && I2C_Req === 1'b1) && cyc < 2000) begin
            @(negedge Clock);
            cyc++;
        end
        HPD = 1'b1;
        @(negedge Clock);
        HPD = 1'b0;
        cyc = 0;
        while (!(Done === 1'b1 && got_q.size() >= 24) && cyc < 5000) begin
            @(negedge Clock);
            cyc++;
        end
        chk("hpd_mid_second_done", Done, 1'b1);
        repeat (30) @(negedge Clock);
        chk("hpd_mid_total", 16'(got_q.size()), 16'd24);
        chk("hpd_mid_rerun_first", (got_q.size() > 12) ? got_q[12] : 16'h0000, 16'h4110);
        chk("hpd_mid_idle", {Busy, Done}, 2'b00);
`else
        // Without the re-init option HPD has no effect.
        got_q.delete();
        @(negedge Clock);
        HPD = 1'b1;
        repeat (10) @(negedge Clock);
        chk("hpd_ignored_busy", Busy, 1'b0);
        chk("hpd_ignored_count", 16'(got_q.size()), 16'd0);
        HPD = 1'b0;
`endif

        chk("req_stable_devaddr", 16'(stable_err), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adv7513_init_sequencer.md
ADV7513_INIT_SEQUENCER -- requirements
Module: adv7513_init_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'h72, ADV7513 8-bit write address driven on I2C_DevAddr.
REQ-002 SHALL have parameter RETRY_MAX, default 3, NACK retries allowed per table entry (range 0-7).
REQ-003 SHALL have port Clock  in  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  in  1  request to run the init sequence; level, sampled in IDLE only.
REQ-006 SHALL have port HPD  in  1  ADV7513 hot-plug detect, already synchronous to Clock.
REQ-007 SHALL have port I2C_Req  out  1  write request to the I2C master.
REQ-008 SHALL have ports I2C_DevAddr, I2C_RegAddr, I2C_Data  out  8 each  device address, register address and data of the current write.
REQ-009 SHALL have port I2C_Ack  in  1  one-cycle completion pulse from the I2C master.
REQ-010 SHALL have port I2C_Nack  in  1  NACK flag, valid only in the I2C_Ack cycle.
REQ-011 SHALL have ports Busy, Done, Error  out  1 each  status levels.
REQ-012 SHALL have port Index  out  4  table entry currently being written.

Function
REQ-013 SHALL hold an internal 12-entry ROM of {reg,data}, written in this order: 41/10, 98/03, 9A/E0, 9C/30, 9D/61, A2/A4, A3/A4, E0/D0, F9/00, 15/00, 16/30, AF/04.
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, GAP, DONE and ERROR.
REQ-015 SHALL move IDLE->ISSUE in the cycle after Start is sampled high, with Index=0 and the retry count cleared.
REQ-016 SHALL, in ISSUE and WAIT, drive I2C_Req=1 with I2C_DevAddr=DEV_ADDR and I2C_RegAddr/I2C_Data=ROM[Index], all held stable until I2C_Ack.
REQ-017 SHALL go ISSUE->WAIT unconditionally after one cycle, and stay in WAIT until I2C_Ack=1.
REQ-018 SHALL, on I2C_Ack with I2C_Nack=0, clear the retry count, then go to GAP with Index+1, or to DONE if Index=11.
REQ-019 SHALL, on I2C_Ack with I2C_Nack=1, go to GAP with Index unchanged and retry count +1 while retry count<RETRY_MAX, otherwise go to ERROR.
REQ-020 SHALL go GAP->ISSUE after exactly one cycle, with I2C_Req=0 in GAP, so that there is a visible Req low between transactions.
REQ-021 SHALL drive Busy=1 in ISSUE, WAIT and GAP, and Busy=0 elsewhere.
REQ-022 SHALL drive Done=1 only in DONE and Error=1 only in ERROR; both are levels.
REQ-023 SHALL go DONE/ERROR->IDLE when Start=0; while Start stays high, it SHALL remain in DONE/ERROR (no auto-restart).
REQ-024 SHALL ignore I2C_Ack in IDLE, GAP, DONE and ERROR.
REQ-025 SHALL hold Index at its last value in DONE (11) and ERROR (the failing entry).

Reset
REQ-026 SHALL, while Reset=1 (asynchronously), force IDLE, I2C_Req=0, Busy=0, Done=0, Error=0, Index=0, retry count=0, and I2C_DevAddr/I2C_RegAddr/I2C_Data=0.
REQ-027 SHALL treat Reset asserted mid-transaction as an abort: I2C_Req drops immediately and no completion is recorded.
REQ-028 SHALL start from IDLE after Reset is released, with Start sampled on the first rising edge.

Configuration
REQ-029 SHALL, when macro ADV_HPD_REINIT_EN is defined, detect a rising edge of HPD (registered previous value) and treat it as Start in IDLE, DONE or ERROR, restarting at Index 0 on the next cycle.
REQ-030 SHALL, with ADV_HPD_REINIT_EN defined, ignore an HPD edge during ISSUE, WAIT or GAP, and re-run once after reaching DONE/ERROR if such an edge occurred.
REQ-031 SHALL, without ADV_HPD_REINIT_EN, ignore HPD entirely; the port remains present.

Verification
REQ-032 SHALL cover a clean run: Start pulse, master acks every write after 5 cycles -> 12 Req transactions in ROM order (first 41/10, last AF/04), then Done=1, Index=11, Busy=0.
REQ-033 SHALL cover a single NACK: NACK on entry 3 once, RETRY_MAX=3 -> 9C/30 is issued twice, the sequence completes, and Done=1.
REQ-034 SHALL cover persistent NACK: entry 5 always NACKs with RETRY_MAX=3 -> exactly 4 attempts at A2/A4, then Error=1, Index=5, I2C_Req=0.
REQ-035 SHALL cover reset mid-run: Reset pulsed in WAIT of entry 7 -> outputs are at reset values in the same cycle, and a new Start restarts at 41/10.
REQ-036 SHALL cover Start held high: the sequence completes and the block stays in DONE, with no second run; dropping Start returns it to IDLE.
REQ-037 SHALL cover HPD re-init with ADV_HPD_REINIT_EN defined: HPD 0->1 in DONE -> a new run from Index 0; HPD 0->1 during entry 4 -> exactly one extra run after DONE.
